// File: rtl/div_sequencer.sv
// div_sequencer - 32-cycle restoring divider for div/divu with HI/LO interlock.
// Fixed 35-edge latency from Start to Done; results change only when Done rises.
module div_sequencer #(
  parameter logic [31:0] ZERO_DIV_Q = 32'hFFFFFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Start,
  input  logic        Signed,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  input  logic        HiLo_Read,
  output logic        Busy,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] Quotient,
  output logic [31:0] Remainder
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_FIX, S_DONE} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] a_q, b_q;
  logic        signed_q;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic        busy_q, done_q;
  logic [31:0] quotient_q, remainder_q;

  logic [32:0] rem_shift_d, rem_diff_d;
  logic [31:0] a_mag_d, b_mag_d, quo_fix_d, rem_fix_d;

  always_comb begin
    a_mag_d     = (signed_q && a_q[31]) ? 32'(-a_q) : a_q;
    b_mag_d     = (signed_q && b_q[31]) ? 32'(-b_q) : b_q;
    rem_shift_d = {rem_q, quo_q[31]};
    rem_diff_d  = rem_shift_d - {1'b0, dvs_q};
    quo_fix_d   = (signed_q && (a_q[31] ^ b_q[31])) ? 32'(-quo_q) : quo_q;
    rem_fix_d   = (signed_q && a_q[31]) ? 32'(-rem_q) : rem_q;
    // A zero divisor reports a fixed quotient and hands the dividend back untouched.
    if (b_q == 32'd0) begin
      quo_fix_d = ZERO_DIV_Q;
      rem_fix_d = a_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      signed_q    <= 1'b0;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      dvs_q       <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (Start && !Flush) begin
            a_q      <= A;
            b_q      <= B;
            signed_q <= Signed;
            busy_q   <= 1'b1;
            state_q  <= S_PREP;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_PREP: begin
          if (Flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            quo_q   <= a_mag_d;
            dvs_q   <= b_mag_d;
            rem_q   <= 32'd0;
            cnt_q   <= 5'd0;
            state_q <= S_DIV;
          end
        end
        S_DIV: begin
          if (Flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            // Keep the trial difference only when it did not go negative.
            rem_q <= rem_diff_d[32] ? rem_shift_d[31:0] : rem_diff_d[31:0];
            quo_q <= {quo_q[30:0], ~rem_diff_d[32]};
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          busy_q <= 1'b0;
          if (Flush) begin
            state_q <= S_IDLE;
          end else begin
            quotient_q  <= quo_fix_d;
            remainder_q <= rem_fix_d;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy      = busy_q;
  assign Stall     = busy_q & (HiLo_Read | Start);
  assign Done      = done_q;
  assign Quotient  = quotient_q;
  assign Remainder = remainder_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - scoreboard bench for div_sequencer with directed vectors.
module tb_div_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic        Signed = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Flush = 1'b0;
  logic        HiLo_Read = 1'b0;
  logic        Busy, Stall, Done;
  logic [31:0] Quotient, Remainder;

  div_sequencer dut (
    .clock(clock), .reset(reset), .Start(Start), .Signed(Signed), .A(A), .B(B),
    .Flush(Flush), .HiLo_Read(HiLo_Read), .Busy(Busy), .Stall(Stall), .Done(Done),
    .Quotient(Quotient), .Remainder(Remainder)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (Done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got Done=1 at cycle %0d want no pulse", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("quotient", Quotient, e.q);
        chk("remainder", Remainder, e.r);
      end
    end
  end

  // Caller is positioned at a negedge; Start is sampled at the following posedge.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] eq, input logic [31:0] er);
    exp_t e;
    Start = 1'b1; Signed = s; A = a; B = b;
    @(posedge clock);
    #1;
    Start = 1'b0;
    if (push) begin
      e.cyc = cyc + 34; e.q = eq; e.r = er;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (sb.size() == 0) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er);
    @(negedge clock);
    issue(s, a, b, 1'b1, eq, er);
    drain();
  endtask

  initial begin
    int snap;
    bit seen;
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_quo", Quotient, 32'd0);
    chk("rst_rem", Remainder, 32'd0);
    reset = 1'b0;

    // 100/7 with a HI/LO access and an ignored Start while busy
    @(negedge clock);
    issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2);
    chk("busy_after_start", 32'(Busy), 32'd1);
    repeat (5) @(negedge clock);
    HiLo_Read = 1'b1; Start = 1'b1; A = 32'd5; B = 32'd1;
    #1;
    chk("stall_hilo", 32'(Stall), 32'd1);
    @(posedge clock);
    #1;
    HiLo_Read = 1'b0; Start = 1'b0;
    chk("quo_hold_busy", Quotient, 32'd0);
    drain();
    chk("busy_idle", 32'(Busy), 32'd0);
    HiLo_Read = 1'b1;
    #1;
    chk("stall_idle", 32'(Stall), 32'd0);
    HiLo_Read = 1'b0;

    run(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
    run(1'b0, 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h12345678);
    run(1'b1, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9);
    run(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
    run(1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1);
    run(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);

    // Flush mid-DIV: no Done, results keep the -7/2 values
    snap = done_cnt;
    @(negedge clock);
    issue(1'b0, 32'd50, 32'd5, 1'b0, 32'd0, 32'd0);
    repeat (10) @(negedge clock);
    Flush = 1'b1;
    @(posedge clock);
    #1;
    Flush = 1'b0;
    chk("busy_after_flush", 32'(Busy), 32'd0);
    repeat (30) @(negedge clock);
    chk("flush_no_done", 32'(done_cnt), 32'(snap));
    chk("flush_quo", Quotient, 32'hFFFFFFFD);
    chk("flush_rem", Remainder, 32'hFFFFFFFF);

    // Start and Flush together in IDLE
    Start = 1'b1; Flush = 1'b1; A = 32'd9; B = 32'd3;
    @(posedge clock);
    #1;
    Start = 1'b0; Flush = 1'b0;
    chk("start_flush_idle", 32'(Busy), 32'd0);

    // Asynchronous reset mid-DIV
    @(negedge clock);
    issue(1'b0, 32'd77, 32'd7, 1'b0, 32'd0, 32'd0);
    repeat (21) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("areset_busy", 32'(Busy), 32'd0);
    chk("areset_done", 32'(Done), 32'd0);
    chk("areset_quo", Quotient, 32'd0);
    chk("areset_rem", Remainder, 32'd0);
    #1;
    reset = 1'b0;
    run(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);

    // Back-to-back: second Start sampled in the DONE cycle
    @(negedge clock);
    issue(1'b0, 32'd1000, 32'd10, 1'b1, 32'd100, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (Done === 1'b1) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL b2b_first_done: got no Done want pulse");
    end
    issue(1'b0, 32'hFFFFFFFF, 32'h10, 1'b1, 32'h0FFFFFFF, 32'hF);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
